// File: rtl/seven_seg_reader.sv
// Reads back a multiplexed seven-segment bus: waits for a pattern to be stable on one
// digit, decodes it to hex, emits it on a valid/ready port and keeps a per-digit frame.
module seven_seg_reader #(
    parameter int DIGITS = 4,
    parameter int STABLE = 3,
    localparam int DW = $clog2(DIGITS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [6:0]            seg,
    input  logic [DIGITS-1:0]     dig_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DW-1:0]         out_digit,
    output logic [3:0]            out_value,
    output logic                  out_err,
    output logic                  overrun,
    output logic [4*DIGITS-1:0]   frame,
    output logic                  frame_valid
);

    typedef enum logic [1:0] {IDLE, TRACK, CAPTURED} state_t;

    state_t                state_q, state_d;
    logic [DW-1:0]         cur_digit_q, cur_digit_d;
    logic [6:0]            last_seg_q, last_seg_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [DW-1:0]         out_digit_q, out_digit_d;
    logic [3:0]            out_value_q, out_value_d;
    logic                  out_err_q, out_err_d;
    logic                  overrun_q, overrun_d;
    logic [4*DIGITS-1:0]   frame_q, frame_d;
    logic                  frame_valid_q, frame_valid_d;
    logic [DIGITS-1:0]     seen_q, seen_d;

    logic                  one_hot;
    logic [DW-1:0]         sample_digit;
    logic                  same;
    logic                  capture;
    logic [3:0]            cap_value;
    logic                  cap_err;

    always_comb begin
        one_hot      = (dig_en != '0) && ((dig_en & (dig_en - DIGITS'(1))) == '0);
        sample_digit = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (dig_en[i]) sample_digit = DW'(i);
        end
        same = (cur_digit_q == sample_digit) && (last_seg_q == seg);
    end

    always_comb begin
        cap_err = 1'b0;
        case (seg)
            7'h3F: cap_value = 4'h0;
            7'h06: cap_value = 4'h1;
            7'h5B: cap_value = 4'h2;
            7'h4F: cap_value = 4'h3;
            7'h66: cap_value = 4'h4;
            7'h6D: cap_value = 4'h5;
            7'h7D: cap_value = 4'h6;
            7'h07: cap_value = 4'h7;
            7'h7F: cap_value = 4'h8;
            7'h6F: cap_value = 4'h9;
            7'h77: cap_value = 4'hA;
            7'h7C: cap_value = 4'hB;
            7'h39: cap_value = 4'hC;
            7'h5E: cap_value = 4'hD;
            7'h79: cap_value = 4'hE;
            7'h71: cap_value = 4'hF;
            default: begin
                cap_value = 4'h0;
                cap_err   = 1'b1;
            end
        endcase
    end

    // Tracker: any new pattern (or return from a gap) restarts the count at 1.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cur_digit_d = cur_digit_q;
        last_seg_d  = last_seg_q;
        capture     = 1'b0;
        if (!one_hot) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q != IDLE && same) begin
            if (state_q == TRACK) begin
                if (({1'b0, cnt_q} + 5'd1) >= 5'(STABLE)) begin
                    capture = 1'b1;
                    state_d = CAPTURED;
                    cnt_d   = 4'(STABLE);
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
        end else begin
            cur_digit_d = sample_digit;
            last_seg_d  = seg;
            cnt_d       = 4'd1;
            if (STABLE == 1) begin
                capture = 1'b1;
                state_d = CAPTURED;
            end else begin
                state_d = TRACK;
            end
        end
    end

    always_comb begin
        out_valid_d   = out_valid_q;
        out_digit_d   = out_digit_q;
        out_value_d   = out_value_q;
        out_err_d     = out_err_q;
        overrun_d     = overrun_q;
        frame_d       = frame_q;
        seen_d        = seen_q;
        frame_valid_d = 1'b0;
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (capture) begin
            if (!out_valid_q || out_ready) begin
                out_valid_d = 1'b1;
                out_digit_d = sample_digit;
                out_value_d = cap_value;
                out_err_d   = cap_err;
            end else begin
                overrun_d = 1'b1;
            end
            // The frame tracks good captures even when the output event is dropped.
            if (!cap_err) begin
                frame_d[4*int'(sample_digit) +: 4] = cap_value;
                seen_d[sample_digit]               = 1'b1;
            end
        end
        if (seen_d == '1) begin
            frame_valid_d = 1'b1;
            seen_d        = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            cur_digit_q   <= '0;
            last_seg_q    <= '0;
            out_valid_q   <= 1'b0;
            out_digit_q   <= '0;
            out_value_q   <= '0;
            out_err_q     <= 1'b0;
            overrun_q     <= 1'b0;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
            seen_q        <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cur_digit_q   <= cur_digit_d;
            last_seg_q    <= last_seg_d;
            out_valid_q   <= out_valid_d;
            out_digit_q   <= out_digit_d;
            out_value_q   <= out_value_d;
            out_err_q     <= out_err_d;
            overrun_q     <= overrun_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
            seen_q        <= seen_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_digit   = out_digit_q;
    assign out_value   = out_value_q;
    assign out_err     = out_err_q;
    assign overrun     = overrun_q;
    assign frame       = frame_q;
    assign frame_valid = frame_valid_q;

endmodule

// File: tb/tb_seven_seg_reader.sv
// Directed bench for seven_seg_reader (DIGITS=4, STABLE=3): stability counting, scan,
// glitches, illegal glyphs, backpressure and mid-operation reset.
module tb_seven_seg_reader;

    logic        clock = 1'b0;
    logic        reset;
    logic [6:0]  seg;
    logic [3:0]  dig_en;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_digit;
    logic [3:0]  out_value;
    logic        out_err;
    logic        overrun;
    logic [15:0] frame;
    logic        frame_valid;

    int tests = 0;
    int fails = 0;

    // Transfers observed (valid && ready at the negedge before the transferring edge).
    int         ev_cnt = 0;
    int         fv_cnt = 0;
    logic [1:0] ev_digit [64];
    logic [3:0] ev_value [64];
    logic       ev_err   [64];

    seven_seg_reader #(.DIGITS(4), .STABLE(3)) dut (
        .clock      (clock),
        .reset      (reset),
        .seg        (seg),
        .dig_en     (dig_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_digit  (out_digit),
        .out_value  (out_value),
        .out_err    (out_err),
        .overrun    (overrun),
        .frame      (frame),
        .frame_valid(frame_valid)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (out_valid && out_ready && ev_cnt < 64) begin
            ev_digit[ev_cnt] = out_digit;
            ev_value[ev_cnt] = out_value;
            ev_err[ev_cnt]   = out_err;
            ev_cnt++;
        end
        if (frame_valid) fv_cnt++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        dig_en = 4'b0000;
        seg    = 7'h00;
        tick();
        reset  = 1'b0;
    endtask

    initial begin
        int         base;
        int         fvb;
        logic [6:0] scan_seg [4];
        logic [3:0] scan_val [4];
        scan_seg = '{7'h06, 7'h4F, 7'h66, 7'h39};
        scan_val = '{4'h1, 4'h3, 4'h4, 4'hC};

        reset     = 1'b1;
        dig_en    = 4'b0000;
        seg       = 7'h00;
        out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_digit", 32'(out_digit), 0);
        check("rst_value", 32'(out_value), 0);
        check("rst_err", 32'(out_err), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_frame", 32'(frame), 0);
        check("rst_fv", 32'(frame_valid), 0);

        // Single stable digit: one event two edges after the first sample.
        base   = ev_cnt;
        dig_en = 4'b0001;
        seg    = 7'h5B;
        tick();
        check("t1_edge0_valid", 32'(out_valid), 0);
        tick();
        check("t1_edge1_valid", 32'(out_valid), 0);
        tick();
        check("t1_edge2_valid", 32'(out_valid), 1);
        check("t1_digit", 32'(out_digit), 0);
        check("t1_value", 32'(out_value), 2);
        check("t1_err", 32'(out_err), 0);
        tick();
        check("t1_edge3_valid", 32'(out_valid), 0);
        tick();
        check("t1_edge4_valid", 32'(out_valid), 0);
        check("t1_events", 32'(ev_cnt - base), 1);
        check("t1_frame", 32'(frame), 32'h0002);

        // Multiple enables are not a driven digit.
        base   = ev_cnt;
        dig_en = 4'b0011;
        seg    = 7'h3F;
        repeat (4) tick();
        check("multihot_events", 32'(ev_cnt - base), 0);
        check("multihot_valid", 32'(out_valid), 0);

        // Full scan of all four digits.
        do_reset();
        base = ev_cnt;
        fvb  = fv_cnt;
        for (int d = 0; d < 4; d++) begin
            dig_en = 4'(1 << d);
            seg    = scan_seg[d];
            for (int j = 0; j < 4; j++) begin
                tick();
                if (d == 3 && j == 2) check("scan_fv_edge", 32'(frame_valid), 1);
            end
        end
        check("scan_events", 32'(ev_cnt - base), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("scan_ev%0d_digit", i), 32'(ev_digit[base + i]), 32'(i));
            check($sformatf("scan_ev%0d_value", i), 32'(ev_value[base + i]), 32'(scan_val[i]));
        end
        check("scan_frame", 32'(frame), 32'hC431);
        check("scan_fv_count", 32'(fv_cnt - fvb), 1);

        // Glitch: 8 for two samples then 9 for three -> only 9 is captured.
        base   = ev_cnt;
        dig_en = 4'b0001;
        seg    = 7'h7F;
        tick();
        tick();
        seg = 7'h6F;
        tick();
        tick();
        check("glitch_not_yet", 32'(out_valid), 0);
        tick();
        check("glitch_valid", 32'(out_valid), 1);
        check("glitch_value", 32'(out_value), 9);
        tick();
        check("glitch_events", 32'(ev_cnt - base), 1);
        dig_en = 4'b0010;
        seg    = 7'h7C;
        repeat (3) tick();
        check("glyph_b_value", 32'(out_value), 32'hB);
        tick();
        check("glitch_frame", 32'(frame), 32'hC4B9);

        // Illegal glyphs: error events, no frame update, seen untouched.
        do_reset();
        base   = ev_cnt;
        fvb    = fv_cnt;
        dig_en = 4'b0001; seg = 7'h00; repeat (3) tick();
        dig_en = 4'b0010; seg = 7'h09; repeat (3) tick();
        dig_en = 4'b0100; seg = 7'h00; repeat (3) tick();
        check("bad_frame", 32'(frame), 0);
        dig_en = 4'b1000; seg = 7'h71; repeat (3) tick();
        tick();
        check("bad_events", 32'(ev_cnt - base), 4);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bad_ev%0d_err", i), 32'(ev_err[base + i]), 1);
            check($sformatf("bad_ev%0d_value", i), 32'(ev_value[base + i]), 0);
        end
        check("bad_ev3_err", 32'(ev_err[base + 3]), 0);
        check("bad_ev3_value", 32'(ev_value[base + 3]), 32'hF);
        check("bad_frame_d3", 32'(frame), 32'hF000);
        check("bad_no_fv", 32'(fv_cnt - fvb), 0);
        dig_en = 4'b0001; seg = 7'h06; repeat (3) tick();
        dig_en = 4'b0010; seg = 7'h5B; repeat (3) tick();
        dig_en = 4'b0100; seg = 7'h4F; repeat (3) tick();
        tick();
        check("good_frame", 32'(frame), 32'hF321);
        check("good_fv", 32'(fv_cnt - fvb), 1);

        // Backpressure: second capture dropped, frame still updated.
        do_reset();
        out_ready = 1'b0;
        base      = ev_cnt;
        dig_en = 4'b0001; seg = 7'h66; repeat (3) tick();
        check("bp_valid0", 32'(out_valid), 1);
        check("bp_value0", 32'(out_value), 4);
        check("bp_overrun0", 32'(overrun), 0);
        dig_en = 4'b0010; seg = 7'h6D; repeat (3) tick();
        check("bp_valid1", 32'(out_valid), 1);
        check("bp_hold_digit", 32'(out_digit), 0);
        check("bp_hold_value", 32'(out_value), 4);
        check("bp_overrun1", 32'(overrun), 1);
        check("bp_frame", 32'(frame), 32'h0054);
        dig_en = 4'b0000;
        tick();
        tick();
        check("bp_overrun_sticky", 32'(overrun), 1);
        out_ready = 1'b1;
        tick();
        check("bp_drained", 32'(out_valid), 0);
        check("bp_events", 32'(ev_cnt - base), 1);
        check("bp_ev_digit", 32'(ev_digit[base]), 0);
        tick();
        check("bp_overrun_after", 32'(overrun), 1);

        // Reset while an event is pending and a count is in progress.
        out_ready = 1'b0;
        dig_en = 4'b0100; seg = 7'h7D; repeat (3) tick();
        check("mid_valid", 32'(out_valid), 1);
        dig_en = 4'b0001; seg = 7'h06; repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_value", 32'(out_value), 0);
        check("mid_rst_overrun", 32'(overrun), 0);
        check("mid_rst_frame", 32'(frame), 0);
        tick();
        check("mid_fresh1", 32'(out_valid), 0);
        tick();
        check("mid_fresh2", 32'(out_valid), 0);
        tick();
        check("mid_fresh3", 32'(out_valid), 1);
        check("mid_value", 32'(out_value), 1);
        check("mid_frame", 32'(frame), 32'h0001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
